// File: rtl/spike_volley_encoder.sv
// spike_volley_encoder: turns one intensity vector into a time-coded spike volley per gamma cycle
module spike_volley_encoder #(
  parameter int NUM_INPUTS      = 16,
  parameter int LOG_TIME_PERIOD = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_INPUTS*LOG_TIME_PERIOD-1:0] in_intensity,
  input  logic [NUM_INPUTS-1:0]                 in_mask,
  output logic [LOG_TIME_PERIOD:0]              time_val,
  output logic [NUM_INPUTS-1:0]                 spike_volley,
  output logic                                  gamma_start,
  output logic                                  gamma_end,
  output logic                                  busy
);
  localparam int W = NUM_INPUTS * LOG_TIME_PERIOD;
  localparam logic [LOG_TIME_PERIOD:0] T_GAP  = (LOG_TIME_PERIOD+1)'(1 << LOG_TIME_PERIOD);
  localparam logic [LOG_TIME_PERIOD:0] T_LAST = T_GAP - 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t                       state;
  logic [W-1:0]                 act_st, pend_st, in_st;
  logic [NUM_INPUTS-1:0]        act_m, pend_m;
  logic                         pend_vld, xfer;
  logic [LOG_TIME_PERIOD-1:0]   t_next;
  function automatic logic [NUM_INPUTS-1:0] fire(input logic [W-1:0] st,
                                                 input logic [NUM_INPUTS-1:0] m,
                                                 input logic [LOG_TIME_PERIOD-1:0] t);
    logic [NUM_INPUTS-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      f[i] = m[i] && (st[i*LOG_TIME_PERIOD +: LOG_TIME_PERIOD] == t);
    return f;
  endfunction
  // (T-1) - x over L bits is the bitwise complement of each field
  assign in_st  = ~in_intensity;
  assign xfer   = in_valid && in_ready;
  assign t_next = time_val[LOG_TIME_PERIOD-1:0] + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      time_val     <= '0;
      spike_volley <= '0;
      gamma_start  <= 1'b0;
      gamma_end    <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b1;
      pend_vld     <= 1'b0;
      act_st       <= '0;
      act_m        <= '0;
      pend_st      <= '0;
      pend_m       <= '0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          act_st       <= in_st;
          act_m        <= in_mask;
          spike_volley <= fire(in_st, in_mask, '0);
          gamma_start  <= 1'b1;
          busy         <= 1'b1;
          state        <= RUN;
        end
        RUN: begin
          gamma_start <= 1'b0;
          if (xfer) begin
            pend_st  <= in_st;
            pend_m   <= in_mask;
            pend_vld <= 1'b1;
            in_ready <= 1'b0;
          end
          if (time_val == T_LAST) begin
            state        <= GAP;
            time_val     <= T_GAP;
            spike_volley <= '0;
            gamma_end    <= 1'b1;
          end else begin
            time_val     <= {1'b0, t_next};
            spike_volley <= fire(act_st, act_m, t_next);
          end
        end
        GAP: begin
          gamma_end <= 1'b0;
          in_ready  <= 1'b1;
          time_val  <= '0;
          if (pend_vld) begin
            act_st       <= pend_st;
            act_m        <= pend_m;
            pend_vld     <= 1'b0;
            spike_volley <= fire(pend_st, pend_m, '0);
            gamma_start  <= 1'b1;
            state        <= RUN;
          end else if (xfer) begin
            act_st       <= in_st;
            act_m        <= in_mask;
            spike_volley <= fire(in_st, in_mask, '0);
            gamma_start  <= 1'b1;
            state        <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
